// File: rtl/rmt_regs_pkg.sv
// Shared constants, decode types and the offset decoder for the RMT AXI-Lite register file.
package rmt_regs_pkg;

    localparam int unsigned REG_W = 32;
    localparam int unsigned IDX_W = 5;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [11:0] CTRL_BASE_OFF = 12'h000;
    localparam logic [11:0] STAT_BASE_OFF = 12'h100;
    localparam logic [31:0] UNMAPPED_DATA = 32'hABCDDCBA;

    typedef enum logic [1:0] {
        DEC_CTRL,
        DEC_STAT,
        DEC_MISS
    } dec_kind_e;

    typedef struct packed {
        dec_kind_e        kind;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Offsets below a bank base wrap to huge word indices, so one upper-bound test covers both ends.
    function automatic dec_t decode(input logic hit, input logic [11:0] off,
                                    input int unsigned n_rw, input int unsigned n_ro);
        dec_t        r;
        logic [11:0] crel;
        logic [11:0] srel;
        crel   = off - CTRL_BASE_OFF;
        srel   = off - STAT_BASE_OFF;
        r.kind = DEC_MISS;
        r.idx  = '0;
        if (hit && (32'(crel[11:2]) < n_rw)) begin
            r.kind = DEC_CTRL;
            r.idx  = crel[6:2];
        end else if (hit && (32'(srel[11:2]) < n_ro)) begin
            r.kind = DEC_STAT;
            r.idx  = srel[6:2];
        end
        return r;
    endfunction

endpackage

// File: rtl/rmt_axil_wr_slot.sv
// One-entry AW and W holding slots; commit fires while both are full and clears them both.
module rmt_axil_wr_slot
    import rmt_regs_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = REG_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aw_hs_i,
    input  logic [ADDR_W-1:0]     awaddr_i,
    input  logic                  w_hs_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    output logic                  aw_full_d_c,
    output logic                  w_full_d_c,
    output logic                  commit_c,
    output logic [ADDR_W-1:0]     addr_o,
    output logic [DATA_W-1:0]     data_o,
    output logic [DATA_W/8-1:0]   strb_o
);

    logic                  aw_full_q;
    logic                  w_full_q;
    logic [ADDR_W-1:0]     addr_q,  addr_d;
    logic [DATA_W-1:0]     data_q,  data_d;
    logic [DATA_W/8-1:0]   strb_q,  strb_d;

    always_comb begin
        commit_c    = aw_full_q & w_full_q;
        aw_full_d_c = commit_c ? 1'b0 : (aw_full_q | aw_hs_i);
        w_full_d_c  = commit_c ? 1'b0 : (w_full_q | w_hs_i);
        addr_d      = aw_hs_i ? awaddr_i : addr_q;
        data_d      = w_hs_i ? wdata_i : data_q;
        strb_d      = w_hs_i ? wstrb_i : strb_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            aw_full_q <= aw_full_d_c;
            w_full_q  <= w_full_d_c;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

    assign addr_o = addr_q;
    assign data_o = data_q;
    assign strb_o = strb_q;

endmodule

// File: rtl/rmt_axil_regfile.sv
// AXI4-Lite control/status register file for the RMT data-plane shell.
// Define RMT_REGS_STICKY_EN to make status bits sticky until read.
module rmt_axil_regfile
    import rmt_regs_pkg::*;
#(
    parameter int unsigned                   C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned                   C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = C_S_AXI_ADDR_WIDTH'(32'h44020000),
    parameter int unsigned                   N_RW               = 4,
    parameter int unsigned                   N_RO               = 4,
    parameter logic [REG_W-1:0]              C_CTRL_RST_VAL     = 32'h0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [REG_W*N_RW-1:0]             ctrl_regs,
    output logic [N_RW-1:0]                   ctrl_wr_pulse,
    input  logic [REG_W*N_RO-1:0]             status_in,
    output logic [N_RO-1:0]                   status_rd_pulse
);

    localparam int unsigned AW     = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned STRB_W = DW / 8;

    logic [REG_W*N_RW-1:0] ctrl_q,     ctrl_d;
    logic [N_RW-1:0]       wr_pulse_q, wr_pulse_d;
    logic                  bvalid_q,   bvalid_d;
    logic [1:0]            bresp_q,    bresp_d;
    logic                  awready_q,  awready_d;
    logic                  wready_q,   wready_d;
    logic                  arready_q,  arready_d;
    logic                  rvalid_q,   rvalid_d;
    logic [1:0]            rresp_q,    rresp_d;
    logic [DW-1:0]         rdata_q,    rdata_d;
    logic [N_RO-1:0]       rd_pulse_q, rd_pulse_d;
    logic [REG_W*N_RO-1:0] stat_view;

    logic              aw_hs, w_hs, ar_hs;
    logic              aw_full_d, w_full_d, commit;
    logic [AW-1:0]     slot_addr;
    logic [DW-1:0]     slot_data;
    logic [STRB_W-1:0] slot_strb;
    dec_t              wdec, rdec;

    function automatic logic in_window(input logic [AW-1:0] a);
        return a[AW-1:12] == C_BASEADDR[AW-1:12];
    endfunction

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID  & wready_q;
    assign ar_hs = S_AXI_ARVALID & arready_q;

    rmt_axil_wr_slot #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) u_wr_slot (
        .clk         (clk),
        .reset       (reset),
        .aw_hs_i     (aw_hs),
        .awaddr_i    (S_AXI_AWADDR),
        .w_hs_i      (w_hs),
        .wdata_i     (S_AXI_WDATA),
        .wstrb_i     (S_AXI_WSTRB),
        .aw_full_d_c (aw_full_d),
        .w_full_d_c  (w_full_d),
        .commit_c    (commit),
        .addr_o      (slot_addr),
        .data_o      (slot_data),
        .strb_o      (slot_strb)
    );

    assign wdec = decode(in_window(slot_addr), slot_addr[11:0], N_RW, N_RO);
    assign rdec = decode(in_window(S_AXI_ARADDR), S_AXI_ARADDR[11:0], N_RW, N_RO);

`ifdef RMT_REGS_STICKY_EN
    logic [REG_W*N_RO-1:0] sticky_q, sticky_d;

    assign stat_view = sticky_q | status_in;

    // A read returns and clears the accumulated bits; bits arriving on that edge go out with it.
    always_comb begin
        sticky_d = stat_view;
        if (ar_hs && (rdec.kind == DEC_STAT)) begin
            for (int unsigned i = 0; i < N_RO; i++) begin
                if (rdec.idx == IDX_W'(i)) sticky_d[REG_W*i +: REG_W] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sticky_q <= '0;
        else       sticky_q <= sticky_d;
    end
`else
    assign stat_view = status_in;
`endif

    // Write path: commit the held pair into the decoded control register.
    always_comb begin
        ctrl_d     = ctrl_q;
        wr_pulse_d = '0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = (wdec.kind == DEC_CTRL) ? RESP_OKAY : RESP_SLVERR;
            for (int unsigned i = 0; i < N_RW; i++) begin
                if ((wdec.kind == DEC_CTRL) && (wdec.idx == IDX_W'(i))) begin
                    wr_pulse_d[i] = 1'b1;
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (slot_strb[b]) ctrl_d[REG_W*i + 8*b +: 8] = slot_data[8*b +: 8];
                    end
                end
            end
        end
        awready_d = ~aw_full_d & ~bvalid_d;
        wready_d  = ~w_full_d & ~bvalid_d;
    end

    // Read path: data and response are captured on the AR handshake edge.
    always_comb begin
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        rd_pulse_d = '0;
        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = DW'(UNMAPPED_DATA);
            case (rdec.kind)
                DEC_CTRL: begin
                    for (int unsigned i = 0; i < N_RW; i++) begin
                        if (rdec.idx == IDX_W'(i)) rdata_d = ctrl_q[REG_W*i +: REG_W];
                    end
                end
                DEC_STAT: begin
                    for (int unsigned i = 0; i < N_RO; i++) begin
                        if (rdec.idx == IDX_W'(i)) begin
                            rdata_d       = stat_view[REG_W*i +: REG_W];
                            rd_pulse_d[i] = 1'b1;
                        end
                    end
                end
                default: rresp_d = RESP_SLVERR;
            endcase
        end
        arready_d = ~rvalid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= {N_RW{C_CTRL_RST_VAL}};
            wr_pulse_q <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            rd_pulse_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            wr_pulse_q <= wr_pulse_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

    assign S_AXI_AWREADY   = awready_q;
    assign S_AXI_WREADY    = wready_q;
    assign S_AXI_BVALID    = bvalid_q;
    assign S_AXI_BRESP     = bresp_q;
    assign S_AXI_ARREADY   = arready_q;
    assign S_AXI_RVALID    = rvalid_q;
    assign S_AXI_RRESP     = rresp_q;
    assign S_AXI_RDATA     = rdata_q;
    assign ctrl_regs       = ctrl_q;
    assign ctrl_wr_pulse   = wr_pulse_q;
    assign status_rd_pulse = rd_pulse_q;

endmodule

// File: doc/rmt_axil_regfile.md
# rmt_axil_regfile

Parametrised AXI4-Lite control/status register file for the RMT data-plane shell. It supersedes the fixed single-register CPU block with:
- N_RW writable control registers and N_RO read-only status registers;
- independent AW/W channel acceptance;
- SLVERR on unmapped access;
- per-register write/read strobes.

It sits between the host AXI-Lite interconnect and pipeline configuration logic, which uses it for VLAN drop flags, tokens and counters.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
- C_S_AXI_ADDR_WIDTH, 32, address width
- C_BASEADDR, 32'h44020000, window base; window is 4 KB and aligned
- N_RW, 4, control registers (1..32)
- N_RO, 4, status registers (1..32)
- C_CTRL_RST_VAL, 32'h0, reset value of every control register
- clk  in  1  sole clock; AXI ports are synchronous to it
- reset  in  1  asynchronous, active-high reset
- S_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY  AXI4-Lite write channels, standard widths
- S_AXI_ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  AXI4-Lite read channels
- ctrl_regs  out  32*N_RW  control register contents; register i is bits [32i+:32]
- ctrl_wr_pulse  out  N_RW  one-cycle pulse on the cycle after register i commits a write
- status_in  in  32*N_RO  status sources
- status_rd_pulse  out  N_RO  one-cycle pulse on the cycle after status register i is read

## Operation
- **Decode.**
  - Hit when ADDR[ADDR_W-1:12] == C_BASEADDR[ADDR_W-1:12]. Offset is ADDR[11:0]; bits [1:0] are ignored.
  - Control register i is at 0x000 + 4i. Status register i is at 0x100 + 4i.
- **Writes.**
  - AW and W are captured independently into one-entry holding slots, in any order or in the same cycle.
  - When both slots are full, the write commits and both slots clear.
  - A commit to control register i applies byte lanes whose WSTRB bit is set; other lanes are unchanged. BRESP=OKAY.
  - A write to a status address, an unused offset, or an off-window address changes nothing and returns BRESP=SLVERR (2'b10).
- **Reads.**
  - Control register i returns its current value.
  - Status register i returns status_in (see Configuration for sticky mode).
  - Unmapped reads return 32'hABCDDCBA with RRESP=SLVERR. All mapped reads return OKAY.
- **Ordering.** One outstanding write and one outstanding read. Read and write paths are fully independent.
- **Reset values.** All READY/VALID outputs = 0. BRESP/RRESP/RDATA = 0. ctrl_regs = C_CTRL_RST_VAL. Pulses = 0. Holding slots empty.
- **Reset mid-transaction.** Pending slots and response valids are dropped. No partial write is committed.

## Timing
- **Ready equations.**
  - AWREADY = ~aw_full & ~BVALID.
  - WREADY = ~w_full & ~BVALID.
  - ARREADY = ~RVALID.
  - All three are driven from registers only; there is no combinational path from any VALID.
- **Write latency.**
  - Edge E0: the last of AW/W is captured.
  - Edge E1: register updates, BVALID rises, slots clear.
  - Cycle after E1: ctrl_wr_pulse[i] is high.
  - AW and W handshakes on the same edge give the same E0/E1 timing.
- **Write response.** BVALID holds until BREADY. A new AW/W is accepted no earlier than the cycle after the B handshake.
- **Read latency.** RDATA, RRESP and RVALID are registered at the AR handshake edge, so RVALID is high the next cycle. RVALID holds with stable data until RREADY.
- **Back-to-back reads.** Throughput is one read per 2 cycles with RREADY held high.
- **Read/write collision.** A read whose AR handshake edge is at or before the write's commit edge E1 returns the pre-write value.

## Configuration
- **RMT_REGS_STICKY_EN defined.** Each status bit is sticky: sticky <= sticky | status_in every cycle.
  - A read returns sticky | status_in sampled at the AR handshake edge. Sticky clears at that same edge.
  - A bit set by status_in on the clearing edge is still returned by that read and is not retained afterwards.
  - Reset clears sticky.
- **Undefined.** Status reads return status_in sampled at the AR handshake edge. No sticky storage is synthesised.

## Structure
- **Package rmt_regs_pkg:**
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - CTRL_BASE_OFF=12'h000, STAT_BASE_OFF=12'h100;
  - UNMAPPED_DATA=32'hABCDDCBA;
  - decode result enum {DEC_CTRL, DEC_STAT, DEC_MISS}.
- **Sub-module rmt_axil_wr_slot:** the one-entry AW/W holding pair with full flags and the commit strobe, instantiated once.

## Test plan
- **Write then read.**
  - Stimulus: write 0xDEADBEEF to 0x44020004 with WSTRB=4'hF; after the response, read it back.
  - Response: BRESP=00; ctrl_regs[63:32]=0xDEADBEEF; ctrl_wr_pulse=4'b0010 for exactly 1 cycle; RDATA=0xDEADBEEF.
- **W before AW.**
  - Stimulus: WVALID 3 cycles ahead of AWVALID, WSTRB=4'b0101, data 0x11223344 to register 0, which holds 0.
  - Response: register 0 = 0x00220044; BVALID exactly 1 cycle after AW handshake.
- **Unmapped and status write.**
  - Stimulus: write 0x44020108.
  - Response: BRESP=10; no ctrl_wr_pulse; no register change.
  - Stimulus: read 0x44020ABC.
  - Response: RDATA=0xABCDDCBA, RRESP=10.
- **Sticky mode (RMT_REGS_STICKY_EN).**
  - Stimulus: 1-cycle status_in[0]=1, then read 0x44020100 twice.
  - Response: first RDATA=1, second RDATA=0; status_rd_pulse[0] is high after each read.
- **Backpressure and reset.**
  - Stimulus: hold BREADY=0 for 10 cycles.
  - Response: BVALID held; AWREADY=WREADY=0 throughout.
  - Stimulus: assert reset mid-wait.
  - Response: BVALID=0 immediately; ctrl_regs=C_CTRL_RST_VAL.
